// File: rtl/wrap_fetch_sequencer.sv
// Per-wrap PC file and round-robin fetch scheduler feeding a registered icache request slot.
// Optional macro WRAP_FETCH_PERF_EN adds the perf_starve_cycles counter port.

module wrap_fetch_state #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  INSTR_BYTES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                grant,
    input  logic                resp_clr,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pending,
    output logic                epoch
);
    localparam logic [PC_WIDTH-1:0] INC  = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] MASK = ~PC_WIDTH'(INSTR_BYTES - 1);

    // Redirect wins over everything; grant and a matching response never coincide
    // because a pending wrap is never granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            pending <= 1'b0;
            epoch   <= 1'b0;
        end else if (redirect) begin
            pc      <= redirect_pc & MASK;
            pending <= 1'b0;
            epoch   <= ~epoch;
        end else if (grant) begin
            pc      <= pc + INC;
            pending <= 1'b1;
        end else if (resp_clr) begin
            pending <= 1'b0;
        end
    end
endmodule

module wrap_fetch_sequencer #(
    parameter int                  NUM_WRAPS   = 4,
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                  INSTR_BYTES = 4,
    localparam int                 WW          = $clog2(NUM_WRAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WRAPS-1:0] wrap_enable,
    output logic                 ic_req_valid,
    input  logic                 ic_req_ready,
    output logic [PC_WIDTH-1:0]  ic_req_pc,
    output logic [WW-1:0]        ic_req_wrap,
    output logic                 ic_req_epoch,
    input  logic                 ic_resp_valid,
    input  logic [WW-1:0]        ic_resp_wrap,
    input  logic                 ic_resp_epoch,
    input  logic                 rb_valid,
    input  logic [WW-1:0]        rb_wrap,
    input  logic [PC_WIDTH-1:0]  rb_pc
`ifdef WRAP_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_starve_cycles
`endif
);
    logic [NUM_WRAPS-1:0][PC_WIDTH-1:0] pc_q;
    logic [NUM_WRAPS-1:0]               pending_q;
    logic [NUM_WRAPS-1:0]               epoch_q;
    logic [NUM_WRAPS-1:0]               eligible;
    logic [NUM_WRAPS-1:0]               grant;
    logic [NUM_WRAPS-1:0]               resp_clr;
    logic [NUM_WRAPS-1:0]               rb_hit;
    logic [WW-1:0]                      rr_ptr;
    logic [WW-1:0]                      sel;
    logic                               sel_found;
    logic                               slot_free;
    logic                               kill;
    int                                 idx;

    assign slot_free = ~ic_req_valid | ic_req_ready;
    assign kill      = ic_req_valid & ~ic_req_ready & rb_valid & (rb_wrap == ic_req_wrap);

    for (genvar w = 0; w < NUM_WRAPS; w++) begin : g_wrap
        assign rb_hit[w]   = rb_valid & (rb_wrap == WW'(w));
        assign eligible[w] = wrap_enable[w] & ~pending_q[w] & ~rb_hit[w];
        assign resp_clr[w] = ic_resp_valid & (ic_resp_wrap == WW'(w)) & (ic_resp_epoch == epoch_q[w]);
        assign grant[w]    = slot_free & sel_found & (sel == WW'(w));

        wrap_fetch_state #(
            .PC_WIDTH    (PC_WIDTH),
            .RESET_PC    (RESET_PC),
            .INSTR_BYTES (INSTR_BYTES)
        ) u_state (
            .clk         (clk),
            .reset       (reset),
            .grant       (grant[w]),
            .resp_clr    (resp_clr[w]),
            .redirect    (rb_hit[w]),
            .redirect_pc (rb_pc),
            .pc          (pc_q[w]),
            .pending     (pending_q[w]),
            .epoch       (epoch_q[w])
        );
    end

    // rr_ptr holds the first wrap to search, i.e. last_granted+1.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = 0;
        for (int i = 0; i < NUM_WRAPS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_WRAPS;
            if (!sel_found && eligible[WW'(idx)]) begin
                sel_found = 1'b1;
                sel       = WW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic_req_valid <= 1'b0;
            ic_req_pc    <= '0;
            ic_req_wrap  <= '0;
            ic_req_epoch <= 1'b0;
            rr_ptr       <= '0;
        end else if (slot_free) begin
            ic_req_valid <= sel_found;
            if (sel_found) begin
                ic_req_pc    <= pc_q[sel];
                ic_req_wrap  <= sel;
                ic_req_epoch <= epoch_q[sel];
                rr_ptr       <= (sel == WW'(NUM_WRAPS - 1)) ? '0 : sel + 1'b1;
            end
        end else if (kill) begin
            ic_req_valid <= 1'b0;
        end
    end

`ifdef WRAP_FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_starve_cycles <= '0;
        else if (|wrap_enable && slot_free && !sel_found && perf_starve_cycles != 32'hFFFF_FFFF)
            perf_starve_cycles <= perf_starve_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_wrap_fetch_sequencer.sv
// Scoreboard bench for wrap_fetch_sequencer: directed scenarios plus random traffic
// checked against an array-based reference model of the fetch rules.

module tb_wrap_fetch_sequencer;
    localparam int N = 4;

    typedef struct {
        logic [31:0] pc;
        int          wrap;
        bit          epoch;
    } req_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] en = '0;
    logic         rdy = 1'b0;
    logic         rv = 1'b0;
    logic [1:0]   rw = '0;
    logic         re = 1'b0;
    logic         rbv = 1'b0;
    logic [1:0]   rbw = '0;
    logic [31:0]  rbpc = '0;
    logic         ic_req_valid;
    logic [31:0]  ic_req_pc;
    logic [1:0]   ic_req_wrap;
    logic         ic_req_epoch;
`ifdef WRAP_FETCH_PERF_EN
    logic [31:0]  perf;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_pc[N];
    bit          m_pend[N];
    bit          m_ep[N];
    int          m_next;
    bit          m_valid;
    req_t        m_slot;
    req_t        exp_q[$];
    req_t        infl[$];

    always #5 clk = ~clk;

    wrap_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .wrap_enable   (en),
        .ic_req_valid  (ic_req_valid),
        .ic_req_ready  (rdy),
        .ic_req_pc     (ic_req_pc),
        .ic_req_wrap   (ic_req_wrap),
        .ic_req_epoch  (ic_req_epoch),
        .ic_resp_valid (rv),
        .ic_resp_wrap  (rw),
        .ic_resp_epoch (re),
        .rb_valid      (rbv),
        .rb_wrap       (rbw),
        .rb_pc         (rbpc)
`ifdef WRAP_FETCH_PERF_EN
        ,
        .perf_starve_cycles (perf)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < N; w++) begin
            m_pc[w] = 32'h0; m_pend[w] = 0; m_ep[w] = 0;
        end
        m_next = 0; m_valid = 0; m_slot = '{32'h0, 0, 1'b0};
        exp_q.delete(); infl.delete();
    endtask

    // One clock of the fetch rules, using the inputs present this cycle.
    task automatic model_update();
        int  g;
        bit  free;
        bit  hit;
        req_t r;
        free = !m_valid || rdy;
        if (m_valid && rdy) begin
            exp_q.push_back(m_slot);
            infl.push_back(m_slot);
        end
        hit = rv && (re == m_ep[rw]);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int w;
            w = (m_next + k) % N;
            if (g < 0 && en[w] && !m_pend[w] && !(rbv && int'(rbw) == w)) g = w;
        end
        if (hit) m_pend[rw] = 0;
        if (free) begin
            if (g >= 0) begin
                r.pc = m_pc[g]; r.wrap = g; r.epoch = m_ep[g];
                m_slot = r; m_valid = 1;
                m_pc[g] = m_pc[g] + 32'd4;
                m_pend[g] = 1;
                m_next = (g + 1) % N;
            end else m_valid = 0;
        end else if (rbv && m_slot.wrap == int'(rbw)) m_valid = 0;
        if (rbv) begin
            m_pc[rbw] = rbpc & ~32'h3;
            m_ep[rbw] = ~m_ep[rbw];
            m_pend[rbw] = 0;
        end
    endtask

    // Inputs are driven at posedge+1; the model steps on the following negedge.
    task automatic step();
        @(negedge clk);
        chk("req_valid", 64'(ic_req_valid), 64'(m_valid));
        model_update();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {en, rdy, rv, rbv} = '0;
        #2;
        chk("rst_valid", 64'(ic_req_valid), 64'h0);
        chk("rst_pc", 64'(ic_req_pc), 64'h0);
        chk("rst_wrap", 64'(ic_req_wrap), 64'h0);
        chk("rst_epoch", 64'(ic_req_epoch), 64'h0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // monitor: pops an expected request on every accepted handshake, checks hold-stability
    initial begin
        logic        pv, prdy, pep;
        logic [31:0] ppc;
        logic [1:0]  pw;
        req_t        e;
        pv = 0; prdy = 0; ppc = '0; pw = '0; pep = 0;
        forever begin
            @(negedge clk); #1;
            if (!reset && ic_req_valid && rdy) begin
                if (exp_q.size() == 0) chk("unexpected_req", 64'(ic_req_valid), 64'h0);
                else begin
                    e = exp_q.pop_front();
                    chk("req_pc", 64'(ic_req_pc), 64'(e.pc));
                    chk("req_wrap", 64'(ic_req_wrap), 64'(e.wrap));
                    chk("req_epoch", 64'(ic_req_epoch), 64'(e.epoch));
                end
            end
            if (!reset && pv && !prdy && ic_req_valid) begin
                chk("hold_pc", 64'(ic_req_pc), 64'(ppc));
                chk("hold_wrap", 64'(ic_req_wrap), 64'(pw));
                chk("hold_epoch", 64'(ic_req_epoch), 64'(pep));
            end
            pv = ic_req_valid && !reset; prdy = rdy; ppc = ic_req_pc; pw = ic_req_wrap; pep = ic_req_epoch;
        end
    end

    initial begin
        req_t r;
        int   pick;
        logic [31:0] c0;
        c0 = '0;
        @(posedge clk); #1;
        do_reset();

        // all wraps enabled, no responses: 0,1,2,3 at PC 0, then idle
        en = 4'hF; rdy = 1;
        for (int i = 0; i < 8; i++) step();
        chk("all_pending_idle", 64'(ic_req_valid), 64'h0);
`ifdef WRAP_FETCH_PERF_EN
        c0 = perf;
        for (int i = 0; i < 10; i++) step();
        chk("perf_starve_delta", 64'(perf - c0), 64'd10);
`endif
        // two more rounds of matching responses: PCs 4 then 8
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 4; i++) begin
                r = infl.pop_front();
                rv = 1; rw = 2'(r.wrap); re = r.epoch;
                step();
            end
            rv = 0;
            for (int i = 0; i < 6; i++) step();
        end

        // stall with wrap 2 in the slot
        r = infl.pop_front(); r = infl.pop_front(); r = infl.pop_front();
        rdy = 0; rv = 1; rw = 2'(r.wrap); re = r.epoch;
        step(); rv = 0; step();
        chk("stall_wrap", 64'(ic_req_wrap), 64'd2);
        for (int i = 0; i < 5; i++) step();
        rdy = 1; step(); step();

        // kill: wrap 1 in slot, stalled, redirected to 0x1003
        do_reset();
        en = 4'b0010; rdy = 0;
        step();
        chk("kill_slot_wrap", 64'(ic_req_wrap), 64'd1);
        rbv = 1; rbw = 2'd1; rbpc = 32'h0000_1003;
        step();
        rbv = 0;
        chk("killed_valid", 64'(ic_req_valid), 64'h0);
        rdy = 1; step();
        chk("reissue_pc", 64'(ic_req_pc), 64'h1000);
        chk("reissue_epoch", 64'(ic_req_epoch), 64'h1);
        step();
        rv = 1; rw = 2'd1; re = 0;
        step(); rv = 0; step(); step();
        chk("stale_ignored", 64'(ic_req_valid), 64'h0);

        // PC wrap-around on wrap 0
        do_reset();
        en = 4'b0001; rdy = 1; rbv = 1; rbw = 0; rbpc = 32'hFFFF_FFFC;
        step(); rbv = 0; step();
        chk("wrap_hi_pc", 64'(ic_req_pc), 64'hFFFF_FFFC);
        step();
        rv = 1; rw = 0; re = 1; step(); rv = 0; step();
        chk("wrap_lo_pc", 64'(ic_req_pc), 64'h0);
        chk("wrap_lo_valid", 64'(ic_req_valid), 64'h1);

        // random traffic
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            if (cyc % 40 == 0) en = 4'($urandom);
            rdy = ($urandom % 4) != 0;
            rv = 0;
            if (infl.size() > 0 && ($urandom % 3) == 0) begin
                pick = int'($urandom % infl.size());
                r = infl[pick]; infl.delete(pick);
                rv = 1; rw = 2'(r.wrap); re = r.epoch;
            end else if (($urandom % 8) == 0) begin
                rv = 1; rw = 2'($urandom); re = ~m_ep[rw];
            end
            rbv = ($urandom % 12) == 0;
            rbw = 2'($urandom);
            rbpc = $urandom;
            step();
        end
        {rv, rbv, rdy} = '0;
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wrap_fetch_sequencer.md
Name: wrap_fetch_sequencer

Overview:
- Per-wrap program-counter file and fetch scheduler for one core.
- Holds one PC per wrap and picks one eligible wrap per cycle by round-robin.
- Issues a registered instruction-cache request with a valid/ready handshake, then advances the chosen PC.
- Accepts rollback/branch redirects from later pipeline stages; a 1-bit epoch per wrap discards stale responses.

Parameters:
- NUM_WRAPS, 4, number of wraps per core (>=2)
- PC_WIDTH, 32, PC width in bits
- RESET_PC, 32'h0000_0000, PC loaded into every wrap on reset
- INSTR_BYTES, 4, PC increment per fetch (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- wrap_enable  in  NUM_WRAPS  per-wrap run enable
- ic_req_valid  out  1  request slot holds a valid request
- ic_req_ready  in  1  icache accepts request this cycle
- ic_req_pc  out  PC_WIDTH  fetch address
- ic_req_wrap  out  $clog2(NUM_WRAPS)  requesting wrap index
- ic_req_epoch  out  1  epoch of requesting wrap at issue
- ic_resp_valid  in  1  icache returns a fetch for a wrap
- ic_resp_wrap  in  $clog2(NUM_WRAPS)  wrap of response
- ic_resp_epoch  in  1  epoch echoed from request
- rb_valid  in  1  redirect request
- rb_wrap  in  $clog2(NUM_WRAPS)  wrap to redirect
- rb_pc  in  PC_WIDTH  new PC for that wrap

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high. While reset is high:
  - all PCs = RESET_PC
  - pending = 0, epoch = 0
  - round-robin pointer = wrap 0
  - request slot empty: ic_req_valid=0, ic_req_pc=0, ic_req_wrap=0, ic_req_epoch=0
- Eligibility: wrap w is eligible when wrap_enable[w]=1, pending[w]=0, and not (rb_valid and rb_wrap==w) in that cycle.
- Slot load:
  - Condition: the slot is free (ic_req_valid=0, or ic_req_valid & ic_req_ready) and at least one wrap is eligible.
  - Selection: the first eligible wrap searched upward from (last_granted+1) mod NUM_WRAPS.
  - Next edge: slot <= {pc[w], w, epoch[w]}; pc[w] <= pc[w]+INSTR_BYTES (mod 2^PC_WIDTH, wrap-around silent); pending[w] <= 1; last_granted <= w.
  - If no wrap is eligible, the slot empties after acceptance.
- Latency: a wrap that is eligible in cycle N appears on ic_req_* in cycle N+1. Back-to-back issue is 1 request/cycle while ready=1.
- Handshake:
  - While ic_req_valid=1 and ic_req_ready=0, ic_req_pc/wrap/epoch hold stable. The only exception is the kill rule below.
  - ic_req_valid never drops without acceptance except on kill.
- Response: ic_resp_valid with ic_resp_epoch==epoch[ic_resp_wrap] clears that pending bit next edge. A mismatching epoch is ignored (stale).
- Redirect: rb_valid sets, next edge:
  - pc[rb_wrap] <= rb_pc with the low log2(INSTR_BYTES) bits forced to 0
  - epoch[rb_wrap] toggles
  - pending[rb_wrap] <= 0
- Kill: if the slot holds rb_wrap and is not accepted in the same cycle, the slot is cleared (ic_req_valid=0 next cycle). If it is accepted in the same cycle, it leaves with the old epoch and its response will be stale.
- Simultaneous events:
  - Redirect beats increment for the same wrap; that wrap is not selected that cycle.
  - Response and redirect for the same wrap: pending ends 0.
  - Response for wrap A while selecting wrap A: impossible, since pending[A]=1 blocks selection.
- wrap_enable deassert: blocks future selection only. An in-flight slot or pending fetch completes normally.
- Reset mid-operation: immediate return to reset values. Responses arriving after reset are stale-filtered only if the epoch differs; the icache is flushed by the same reset.

Optional Feature:
- Macro: WRAP_FETCH_PERF_EN.
- Defined: adds output port perf_starve_cycles (32 bits, reset 0). It increments every cycle in which some wrap_enable bit is set, the slot is free, and no wrap is eligible. It saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then all 4 wraps enabled, ready=1, no responses:
  - Requests: wraps 0,1,2,3 at PC 0 in consecutive cycles starting 1 cycle after enable; then valid drops (all pending).
- Responses with matching epoch for wraps 0..3, ready=1:
  - Next requests: wraps 0,1,2,3 at PC 4; a third round uses PC 8.
- ready=0 for 5 cycles with wrap 2 in the slot:
  - ic_req_* stable for 5 cycles; accepted on first ready=1; no other wrap issued meanwhile.
- Wrap 1 in slot, ready=0, rb_valid wrap1 rb_pc=32'h0000_1003:
  - Slot killed next cycle; epoch[1]=1.
  - Wrap 1 re-issued later at 32'h0000_1000 with ic_req_epoch=1.
  - A response for wrap 1 with epoch 0 is ignored; pending stays 1.
- PC=32'hFFFF_FFFC on wrap 0, issue:
  - Request at FFFF_FFFC; next request after response at 32'h0000_0000.
- With WRAP_FETCH_PERF_EN: all enabled wraps pending, slot free, 10 cycles:
  - perf_starve_cycles increases by exactly 10.
